pipe_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage core. It drives the per-stage `stalled` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- It converts EX branch resolution into a fetch redirect plus if_id bubble, and discards instruction-bus responses that were already in flight at the redirect.
- It implements a debug halt/resume handshake that drains the back-end before reporting halted.
- Sits beside `ctrl` wiring; all stage registers take `stalled_o` and `flush_o` from here.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_fetch_track.sv | 51 +++++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stage indices, stall
// patterns and the control FSM state encoding.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_WB = 4;

  // Each pattern freezes its own stage and everything upstream of it.
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IF   = 5'b00011;
  localparam logic [4:0] STALL_ID   = 5'b00111;
  localparam logic [4:0] STALL_EX   = 5'b01111;
  localparam logic [4:0] STALL_MEM  = 5'b11111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_fetch_track.sv
// Tracks in-flight instruction-bus requests and marks responses that were
// already outstanding at a redirect as stale.
module fetch_track
  import pipe_ctrl_pkg::*;
#(
  parameter int FETCH_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic fetch_valid,
  input  logic flush,
  input  logic in_flush,
  output logic drop_fetch,
  output logic drop_idle,
  output logic fetch_ready
);

  localparam int CW = $clog2(FETCH_DEPTH + 1);

  logic [CW-1:0] outs;
  logic [CW-1:0] drop_cnt;
  logic          valid_eff;

  // A response with nothing outstanding is spurious and must not underflow.
  assign valid_eff   = fetch_valid & (outs != '0);
  assign fetch_ready = (outs < CW'(FETCH_DEPTH)) | fetch_valid;
  assign drop_fetch  = in_flush & (drop_cnt != '0) & fetch_valid;
  assign drop_idle   = (drop_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outs     <= '0;
      drop_cnt <= '0;
    end else begin
      if (fetch_req & ~valid_eff & (outs != CW'(FETCH_DEPTH))) begin
        outs <= outs + 1'b1;
      end else if (valid_eff & ~fetch_req) begin
        outs <= outs - 1'b1;
      end
      // A request issued alongside the flush is the redirected fetch, so it
      // is excluded from the stale count.
      if (flush) begin
        drop_cnt <= outs - CW'(valid_eff);
      end else if (drop_fetch) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage stall vector, branch redirect with stale
// fetch discard, and a debug halt/resume handshake that drains the back-end.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FETCH_DEPTH  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic        fetch_req_i,
  input  logic        fetch_valid_i,
  input  logic        dbg_halt_req_i,
  input  logic        dbg_resume_req_i,
  output logic [4:0]  stalled_o,
  output logic        flush_o,
  output logic [31:0] redirect_addr_o,
  output logic        drop_fetch_o,
  output logic        fetch_ready_o,
  output logic        dbg_halted_o
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e        state, state_next;
  logic [DW-1:0] dcnt, dcnt_next;
  logic          halt_pend, halt_pend_next;
  logic          halted_q;
  logic [4:0]    req_vec;
  logic          drain_step;
  logic          drop_idle;

  always_comb begin
    req_vec = STALL_NONE;
    if (stallreq_mem_i)     req_vec = STALL_MEM;
    else if (stallreq_ex_i) req_vec = STALL_EX;
    else if (stallreq_id_i) req_vec = STALL_ID;
    else if (stallreq_if_i) req_vec = STALL_IF;
  end

  // Outside RUN the front end is frozen and if_id emits bubbles.
  assign stalled_o       = (state != ST_RUN) ? (req_vec | STALL_IF) : req_vec;
  assign flush_o         = ex_branch_flag_i;
  assign redirect_addr_o = ex_branch_flag_i ? ex_branch_addr_i : 32'h0;
  assign dbg_halted_o    = halted_q;
  assign drain_step      = (stalled_o[STG_WB] == NO_STOP) & ~flush_o;

  always_comb begin
    state_next     = state;
    dcnt_next      = dcnt;
    halt_pend_next = halt_pend;
    unique case (state)
      ST_RUN: begin
        if (flush_o) begin
          state_next = ST_FLUSH;
        end else if (dbg_halt_req_i) begin
          state_next     = ST_HALT_DRAIN;
          dcnt_next      = '0;
          halt_pend_next = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (flush_o) begin
          halt_pend_next = halt_pend | dbg_halt_req_i;
        end else if (drop_idle) begin
          halt_pend_next = 1'b0;
          dcnt_next      = '0;
          state_next     = halt_pend ? ST_HALT_DRAIN : ST_RUN;
        end else begin
          halt_pend_next = halt_pend | dbg_halt_req_i;
        end
      end
      ST_HALT_DRAIN: begin
        if (flush_o) begin
          state_next     = ST_FLUSH;
          halt_pend_next = 1'b1;
        end else if (drain_step) begin
          if (dcnt == DW'(DRAIN_CYCLES - 1)) state_next = ST_HALTED;
          else                               dcnt_next  = dcnt + 1'b1;
        end
      end
      ST_HALTED: begin
        if (dbg_resume_req_i) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      dcnt      <= '0;
      halt_pend <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_next;
      dcnt      <= dcnt_next;
      halt_pend <= halt_pend_next;
      halted_q  <= (state_next == ST_HALTED);
    end
  end

  fetch_track #(
    .FETCH_DEPTH(FETCH_DEPTH)
  ) u_fetch_track (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req_i),
    .fetch_valid(fetch_valid_i),
    .flush      (flush_o),
    .in_flush   (state == ST_FLUSH),
    .drop_fetch (drop_fetch_o),
    .drop_idle  (drop_idle),
    .fetch_ready(fetch_ready_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a cycle-level reference model predicts every output
// each cycle; a monitor on the falling edge compares against the queue.
module tb_pipe_ctrl;

  localparam int W = 41;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        br;
  logic [31:0] br_addr;
  logic        f_req, f_valid;
  logic        halt, resume;

  logic [4:0]  stalled_o;
  logic        flush_o;
  logic [31:0] redirect_addr_o;
  logic        drop_fetch_o;
  logic        fetch_ready_o;
  logic        dbg_halted_o;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total = 0;
  int           bad = 0;
  int           drop_seen = 0;

  // reference model state
  int m_mode, m_outs, m_drop, m_dcnt;
  bit m_pend, m_halted, m_known;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if_i   (s_if),
    .stallreq_id_i   (s_id),
    .stallreq_ex_i   (s_ex),
    .stallreq_mem_i  (s_mem),
    .ex_branch_flag_i(br),
    .ex_branch_addr_i(br_addr),
    .fetch_req_i     (f_req),
    .fetch_valid_i   (f_valid),
    .dbg_halt_req_i  (halt),
    .dbg_resume_req_i(resume),
    .stalled_o       (stalled_o),
    .flush_o         (flush_o),
    .redirect_addr_o (redirect_addr_o),
    .drop_fetch_o    (drop_fetch_o),
    .fetch_ready_o   (fetch_ready_o),
    .dbg_halted_o    (dbg_halted_o)
  );

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    string t;
    act = {stalled_o, flush_o, redirect_addr_o, drop_fetch_o, fetch_ready_o, dbg_halted_o};
    if (drop_fetch_o) drop_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got stalled=%b flush=%b addr=%h drop=%b ready=%b halted=%b, exp stalled=%b flush=%b addr=%h drop=%b ready=%b halted=%b",
                 t, act[40:36], act[35], act[34:3], act[2], act[1], act[0],
                 e[40:36], e[35], e[34:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
    br = 0; br_addr = 32'h0; f_req = 0; f_valid = 0; resume = 0;
  endtask

  // Predict this cycle's outputs, queue them, advance the model, clock.
  task automatic tick(input string tag);
    int depth, nmode, ev;
    logic [4:0] st;
    logic drop, ready;
    depth = s_mem ? 5 : s_ex ? 4 : s_id ? 3 : s_if ? 2 : 0;
    st = 5'((1 << depth) - 1);
    if (m_mode != M_RUN) st = st | 5'b00011;
    drop  = (m_mode == M_FLUSH) && (m_drop > 0) && f_valid;
    ready = (m_outs < 2) || f_valid;
    if (m_known) begin
      exp_q.push_back({st, br, (br ? br_addr : 32'h0), drop, ready, m_halted});
      tag_q.push_back(tag);
    end
    if (rst) begin
      m_mode = M_RUN; m_outs = 0; m_drop = 0; m_dcnt = 0;
      m_pend = 0; m_halted = 0; m_known = 1;
    end else begin
      ev = (f_valid && m_outs > 0) ? 1 : 0;
      if (br) m_drop = m_outs - ev;
      else if (drop) m_drop = m_drop - 1;
      m_outs = m_outs + int'(f_req) - ev;
      if (m_outs > 2) m_outs = 2;
      nmode = m_mode;
      case (m_mode)
        M_RUN: begin
          if (br) nmode = M_FLUSH;
          else if (halt) begin nmode = M_DRAIN; m_dcnt = 0; m_pend = 0; end
        end
        M_FLUSH: begin
          if (!br && m_drop_before_zero(drop, br)) begin
            nmode = m_pend ? M_DRAIN : M_RUN;
            m_pend = 0; m_dcnt = 0;
          end else if (halt) m_pend = 1;
        end
        M_DRAIN: begin
          if (br) begin nmode = M_FLUSH; m_pend = 1; end
          else if (!s_mem) begin
            if (m_dcnt == 2) nmode = M_HALTED;
            else m_dcnt++;
          end
        end
        default: if (resume) nmode = M_RUN;
      endcase
      m_mode = nmode;
      m_halted = (m_mode == M_HALTED);
    end
    @(posedge clk);
    #1;
  endtask

  // Stale-count value at the start of the cycle (before this cycle's update).
  int m_drop_start;
  function automatic bit m_drop_before_zero(input logic d, input logic b);
    return (m_drop_start == 0) && !b && (d || !d);
  endfunction

  task automatic step(input string tag);
    m_drop_start = m_drop;
    tick(tag);
  endtask

  initial begin
    int d0;
    m_known = 0; m_mode = M_RUN; m_outs = 0; m_drop = 0; m_dcnt = 0;
    m_pend = 0; m_halted = 0; m_drop_start = 0;
    idle_inputs(); halt = 0; rst = 1;
    @(posedge clk); #1;
    step("reset_a");
    step("reset_b");
    rst = 0;
    step("reset_idle");

    // stall priority
    s_id = 1; s_mem = 1; step("prio_id_mem");
    s_mem = 0;           step("prio_id");
    s_id = 0;            step("prio_none");

    // redirect with two fetches in flight
    f_req = 1; step("fill_1");
    step("fill_2");
    f_req = 0; step("backpressure");
    d0 = drop_seen;
    br = 1; br_addr = 32'h8000_0100; step("redir2_branch");
    br = 0; br_addr = 0; step("redir2_wait");
    f_valid = 1; step("redir2_drop_a");
    f_valid = 0; step("redir2_wait_b");
    f_valid = 1; step("redir2_drop_b");
    f_valid = 0; step("redir2_tail");
    step("redir2_run");
    check("redir2_drop_count", drop_seen - d0, 2);

    // redirect with nothing in flight
    br = 1; br_addr = 32'h0000_2000; step("redir0_branch");
    br = 0; br_addr = 0; step("redir0_bubble");
    step("redir0_run");

    // plain halt, then resume
    halt = 1;
    for (int i = 0; i < 6; i++) step("halt_plain");
    halt = 0; resume = 1; step("resume_a");
    resume = 0; step("resume_b");

    // halt delayed by a two-cycle mem stall
    halt = 1; step("halt_mem_enter");
    step("halt_mem_d0");
    s_mem = 1; step("halt_mem_stall_a");
    step("halt_mem_stall_b");
    s_mem = 0;
    for (int i = 0; i < 4; i++) step("halt_mem_finish");
    halt = 0; resume = 1; step("resume_c");
    resume = 0; step("resume_d");

    // branch while draining
    f_req = 1; step("hd_fill");
    f_req = 0; halt = 1; step("hd_enter");
    br = 1; br_addr = 32'h0000_4440; step("hd_branch");
    br = 0; br_addr = 0; step("hd_flush");
    f_valid = 1; step("hd_drop");
    f_valid = 0;
    for (int i = 0; i < 6; i++) step("hd_redrain");
    halt = 0; resume = 1; step("hd_resume");
    resume = 0; step("hd_run");

    // reset in the middle of a flush
    f_req = 1; step("rf_fill");
    f_req = 0; br = 1; br_addr = 32'h0000_0040; step("rf_branch");
    br = 0; br_addr = 0; step("rf_flush");
    rst = 1; step("rf_reset");
    rst = 0; f_valid = 1; step("rf_after");
    f_valid = 0; step("rf_idle");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      s_if    = ($urandom_range(0, 9) == 0);
      s_id    = ($urandom_range(0, 9) == 0);
      s_ex    = ($urandom_range(0, 11) == 0);
      s_mem   = ($urandom_range(0, 15) == 0);
      br      = ($urandom_range(0, 9) == 0);
      br_addr = br ? $urandom : 32'h0;
      f_valid = ($urandom_range(0, 2) == 0);
      f_req   = ((m_outs < 2) || f_valid) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      resume  = ($urandom_range(0, 7) == 0);
      step("random");
    end
    idle_inputs(); rst = 0; halt = 0;
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
